// File: rtl/vga_rx_decode.sv
// rtl/vga_rx_decode.sv - VGA timing receiver: sync lock FSM, position counters, pixel capture
module vga_rx_decode #(
    parameter int H_SYNC  = 96,
    parameter int H_START = 144,
    parameter int H_VALID = 640,
    parameter int H_TOTAL = 800,
    parameter int V_START = 35,
    parameter int V_VALID = 480,
    parameter int V_TOTAL = 525
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_cnt,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [9:0]  CNT_MAX = 10'h3ff;
    localparam logic [10:0] HS_W    = 11'(H_SYNC);
    localparam logic [9:0]  H_TOT   = 10'(H_TOTAL);
    localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
    localparam logic [9:0]  H_BEG   = 10'(H_START);
    localparam logic [9:0]  H_END   = 10'(H_START + H_VALID);
    localparam logic [9:0]  V_BEG   = 10'(V_START);
    localparam logic [9:0]  V_END   = 10'(V_START + V_VALID);

    state_t      state, state_nxt;
    logic        hs_prev, vs_prev;
    logic [9:0]  h_reg, v_reg;
    logic [9:0]  h_inc, v_inc, h_cur, v_cur;
    logic        hs_rise, hs_fall, vs_rise;
    logic        viol, err_pulse, active;

    assign hs_rise = hsync & ~hs_prev;
    assign hs_fall = ~hsync & hs_prev;
    assign vs_rise = vsync & ~vs_prev;

    assign h_inc = (h_reg == CNT_MAX) ? CNT_MAX : h_reg + 10'd1;
    assign v_inc = (v_reg == CNT_MAX) ? CNT_MAX : v_reg + 10'd1;
    assign h_cur = hs_rise ? 10'd0 : h_inc;
    assign v_cur = hs_rise ? (vs_rise ? 10'd0 : v_inc) : v_reg;

    // h_reg+1 is the high-run length because h restarts at 0 on the rising sample
    assign viol = (hs_rise && (h_inc != H_TOT))
               || (hs_fall && (({1'b0, h_reg} + 11'd1) != HS_W))
               || (vs_rise && (v_inc != V_TOT))
               || (vs_rise && !hs_rise)
               || ((h_cur == CNT_MAX) && (h_reg != CNT_MAX));

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (vs_rise) state_nxt = CHECK;
            CHECK:   if (viol) state_nxt = SEARCH;
                     else if (vs_rise) state_nxt = LOCKED;
            LOCKED:  if (viol) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    assign err_pulse = viol && (state != SEARCH);
    // the violating sample itself is already treated as unlocked
    assign active = (state == LOCKED) && !viol
                 && (h_cur >= H_BEG) && (h_cur < H_END)
                 && (v_cur >= V_BEG) && (v_cur < V_END);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= SEARCH;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            h_reg       <= '0;
            v_reg       <= '0;
            pix_x       <= CNT_MAX;
            pix_y       <= CNT_MAX;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            err_cnt     <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            state       <= state_nxt;
            hs_prev     <= hsync;
            vs_prev     <= vsync;
            h_reg       <= h_cur;
            v_reg       <= v_cur;
            locked      <= (state_nxt == LOCKED);
            sync_err    <= err_pulse;
            if (err_pulse && (err_cnt != 8'hff))
                err_cnt <= err_cnt + 8'd1;
            if (hs_rise)
                line_len <= h_inc;
            if (vs_rise)
                frame_lines <= v_inc;
            pix_valid   <= active;
            pix_x       <= active ? h_cur - H_BEG : CNT_MAX;
            pix_y       <= active ? v_cur - V_BEG : CNT_MAX;
            pix_data    <= active ? rgb_in : 16'd0;
            frame_start <= active && (h_cur == H_BEG) && (v_cur == V_BEG);
        end
    end

endmodule

// File: tb/tb_vga_rx_decode.sv
// tb/tb_vga_rx_decode.sv - randomized bench for vga_rx_decode against a behavioural timing model
module tb_vga_rx_decode;

    localparam int HS  = 8;
    localparam int HST = 12;
    localparam int HV  = 16;
    localparam int HT  = 32;
    localparam int VST = 3;
    localparam int VV  = 6;
    localparam int VT  = 12;
    localparam int M_SEARCH = 0, M_CHECK = 1, M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync = 1'b0, vsync = 1'b0;
    logic [15:0] rgb = '0;
    logic [9:0]  pix_x, pix_y, line_len, frame_lines;
    logic [15:0] pix_data;
    logic        pix_valid, frame_start, locked, sync_err;
    logic [7:0]  err_cnt;

    vga_rx_decode #(
        .H_SYNC(HS), .H_START(HST), .H_VALID(HV), .H_TOTAL(HT),
        .V_START(VST), .V_VALID(VV), .V_TOTAL(VT)
    ) dut (
        .vga_clk(clk), .sys_rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb_in(rgb),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_valid(pix_valid),
        .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
        .err_cnt(err_cnt), .line_len(line_len), .frame_lines(frame_lines)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, valid_cnt = 0;
    int m_h, m_v, m_run, m_state;
    bit m_hsp, m_vsp;
    int e_x, e_y, e_data, e_cnt, e_ll, e_fl;
    bit e_valid, e_fs, e_locked, e_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int a);
        return (a > 1023) ? 1023 : a;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_run = 0; m_state = M_SEARCH; m_hsp = 0; m_vsp = 0;
        e_valid = 0; e_x = 1023; e_y = 1023; e_data = 0; e_fs = 0;
        e_locked = 0; e_err = 0; e_cnt = 0; e_ll = 0; e_fl = 0;
    endtask

    task automatic model_step();
        bit hr, hf, vr, viol, act;
        int nh, nv;
        hr = hsync && !m_hsp;
        hf = !hsync && m_hsp;
        vr = vsync && !m_vsp;
        nh = hr ? 0 : sat(m_h + 1);
        nv = hr ? (vr ? 0 : sat(m_v + 1)) : m_v;
        viol = (hr && sat(m_h + 1) != HT) || (hf && m_run != HS)
            || (vr && sat(m_v + 1) != VT) || (vr && !hr)
            || (nh == 1023 && m_h != 1023);
        if (hr) e_ll = sat(m_h + 1);
        if (vr) e_fl = sat(m_v + 1);
        e_err = viol && (m_state != M_SEARCH);
        if (e_err && e_cnt < 255) e_cnt++;
        act = (m_state == M_LOCKED) && !viol && nh >= HST && nh < HST + HV
           && nv >= VST && nv < VST + VV;
        e_valid = act;
        e_x     = act ? nh - HST : 1023;
        e_y     = act ? nv - VST : 1023;
        e_data  = act ? int'(rgb) : 0;
        e_fs    = act && nh == HST && nv == VST;
        if (m_state == M_SEARCH) begin
            if (vr) m_state = M_CHECK;
        end else if (viol) begin
            m_state = M_SEARCH;
        end else if (vr) begin
            m_state = M_LOCKED;
        end
        e_locked = (m_state == M_LOCKED);
        m_run = hsync ? m_run + 1 : 0;
        m_h = nh; m_v = nv; m_hsp = hsync; m_vsp = vsync;
    endtask

    task automatic compare_all();
        chk("pix_valid", pix_valid, e_valid);
        chk("pix_x", pix_x, e_x);
        chk("pix_y", pix_y, e_y);
        chk("pix_data", pix_data, e_data);
        chk("frame_start", frame_start, e_fs);
        chk("locked", locked, e_locked);
        chk("sync_err", sync_err, e_err);
        chk("err_cnt", err_cnt, e_cnt);
        chk("line_len", line_len, e_ll);
        chk("frame_lines", frame_lines, e_fl);
        if (pix_valid) valid_cnt++;
    endtask

    task automatic cycle(input bit h, input bit v);
        hsync = h; vsync = v; rgb = 16'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_line(input int len, input int hw, input bit von, input int vdel);
        for (int i = 0; i < len; i++) cycle(i < hw, von && i >= vdel);
    endtask

    task automatic send_frame();
        for (int l = 0; l < VT; l++) send_line(HT, HS, l < 2, 0);
    endtask

    task automatic rand_frame();
        int nl, r, len, hw, vd;
        nl = ($urandom % 6 == 0) ? VT - 1 : VT;
        for (int l = 0; l < nl; l++) begin
            r = $urandom % 48; len = HT; hw = HS; vd = 0;
            if (r == 0) len = HT - 1;
            else if (r == 1) len = HT + 1;
            else if (r == 2) hw = HS - 1;
            else if (r == 3 && l == 0) vd = 2;
            send_line(len, hw, l < 2, vd);
        end
    endtask

    int base;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pix_x", pix_x, 10'h3ff);
        chk("rst_pix_y", pix_y, 10'h3ff);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_line_len", line_len, 0);
        rst_n = 1'b1;

        valid_cnt = 0; send_frame(); chk("f1_valid", valid_cnt, 0);
        valid_cnt = 0; send_frame(); chk("f2_valid", valid_cnt, HV * VV);
        valid_cnt = 0; send_frame(); chk("f3_valid", valid_cnt, HV * VV);
        chk("nom_line_len", line_len, HT);
        chk("nom_frame_lines", frame_lines, VT);
        chk("nom_err_cnt", err_cnt, 0);
        chk("nom_locked", locked, 1);

        // one shortened line while locked
        base = e_cnt;
        for (int l = 0; l < VT; l++) send_line((l == 5) ? HT - 1 : HT, HS, l < 2, 0);
        chk("short_err_cnt", err_cnt, base + 1);
        chk("short_locked", locked, 0);
        chk("short_line_len_seen", e_ll, HT);

        for (int f = 0; f < 25; f++) rand_frame();

        // hsync held low long enough to hit the line timeout
        repeat (3) send_frame();
        chk("pre_tmo_locked", locked, 1);
        base = e_cnt;
        send_line(1100, HS, 0, 0);
        cycle(1, 0);
        chk("tmo_line_len", line_len, 1023);
        chk("tmo_locked", locked, 0);
        chk("tmo_err_cnt", err_cnt, base + 1);
        for (int i = 1; i < HT; i++) cycle(i < HS, 0);

        // asynchronous reset in the middle of an active line
        repeat (3) send_frame();
        for (int l = 0; l < 5; l++) send_line(HT, HS, l < 2, 0);
        for (int i = 0; i < 20; i++) cycle(i < HS, 0);
        chk("pre_rst_valid", pix_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pix_valid", pix_valid, 0);
        chk("arst_pix_x", pix_x, 10'h3ff);
        chk("arst_pix_data", pix_data, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_frame_lines", frame_lines, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        valid_cnt = 0; send_frame(); chk("post_rst_f1_valid", valid_cnt, 0);
        valid_cnt = 0; send_frame(); chk("post_rst_f2_valid", valid_cnt, HV * VV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rx_decode.md
VGA_RX_DECODE -- requirements
Module: vga_rx_decode

Interface
REQ-001 Parameters (name, default, meaning): H_SYNC 96 hsync width clocks; H_START 144 first active clock after hsync rise; H_VALID 640 active pixels/line; H_TOTAL 800 clocks/line; V_START 35 first active line after vsync rise; V_VALID 480 active lines; V_TOTAL 525 lines/frame.
REQ-002 Ports (name direction width meaning):
- vga_clk in 1 pixel clock.
- sys_rst_n in 1 asynchronous active-low reset.
- hsync in 1 line sync, active high.
- vsync in 1 frame sync, active high.
- rgb_in in 16 RGB565 pixel.
- pix_x out 10 active column.
- pix_y out 10 active row.
- pix_data out 16 captured pixel.
- pix_valid out 1 pix_x/pix_y/pix_data valid.
- frame_start out 1 one-cycle pulse with pixel (0,0).
- locked out 1 timing lock.
- sync_err out 1 one-cycle pulse on timing violation.
- err_cnt out 8 violation count.
- line_len out 10 last measured line period.
- frame_lines out 10 last measured frame length.
REQ-003 The block SHALL use one clock, vga_clk; reset SHALL be asynchronous, active-low, on sys_rst_n.

Function
REQ-004 hsync, vsync and rgb_in SHALL be sampled together on every vga_clk rising edge; sync rise = sample high while the previous sample was low.
REQ-005 Horizontal position h SHALL be 0 on the hsync-rise sample, +1 per clock after that, and saturate at 1023.
REQ-006 Line index v SHALL be 0 on an hsync rise coinciding with a vsync rise, +1 on every other hsync rise, and saturate at 1023.
REQ-007 line_len SHALL load min(h+1, 1023) on each hsync rise; nominal 800.
REQ-008 frame_lines SHALL load min(v+1, 1023) on each vsync rise; nominal 525.
REQ-009 Violations: line period != H_TOTAL; hsync high run != H_SYNC, checked at the hsync fall; frame_lines != V_TOTAL; vsync rise without a coincident hsync rise; h reaching 1023 (line timeout).
REQ-010 FSM states: SEARCH, CHECK, LOCKED. Reset state SHALL be SEARCH.
REQ-011 SEARCH -> CHECK on a vsync rise; violations SHALL be ignored in SEARCH.
REQ-012 CHECK -> LOCKED on the next vsync rise if no violation occurred since entry; any violation in CHECK SHALL go to SEARCH.
REQ-013 LOCKED -> SEARCH on any violation.
REQ-014 sync_err SHALL pulse once per violation clock in CHECK or LOCKED; err_cnt SHALL increment with each pulse and saturate at 255.
REQ-015 Simultaneous vsync rise and violation in CHECK: the violation wins, next state SEARCH.
REQ-016 locked SHALL be high exactly while the state is LOCKED, registered.
REQ-017 Active sample: state LOCKED, H_START <= h < H_START+H_VALID, and V_START <= v < V_START+V_VALID.
REQ-018 One clock after an active sample: pix_valid=1, pix_x=h-H_START, pix_y=v-V_START, pix_data=sampled rgb_in; otherwise pix_valid=0, pix_x=pix_y=10'h3ff, pix_data=0.
REQ-019 frame_start SHALL pulse in the same cycle as pix_valid with pix_x=0, pix_y=0.
REQ-020 Output latency SHALL be exactly one clock from input sample to output; all outputs SHALL be registered.
REQ-021 Losing lock mid-line SHALL deassert pix_valid from the cycle after the violating sample.

Reset
REQ-022 On sys_rst_n low, immediately and regardless of clock: state SEARCH; h=v=0; previous sync samples=0; pix_valid=0; pix_x=pix_y=10'h3ff; pix_data=0; frame_start=0; locked=0; sync_err=0; err_cnt=0; line_len=0; frame_lines=0.
REQ-023 Reset asserted mid-frame SHALL discard lock; after release the block SHALL need a full SEARCH -> CHECK -> LOCKED sequence before outputting pixels.

Verification
REQ-024 Nominal 800x525 stream (hsync high h 0..95, vsync high lines 0..1, rgb=16'hF800) -> locked=1 the cycle after the second vsync rise; no sync_err; line_len=800; frame_lines=525.
REQ-025 Locked, rgb=h-dependent ramp -> first pix_valid one clock after sample h=144, v=35, with x=0, y=0, frame_start=1; last pix_valid at x=639, y=479; 307200 valid cycles per frame.
REQ-026 Locked, one line shortened to 799 clocks -> sync_err pulses once at that hsync rise; err_cnt=1; locked=0 next cycle; line_len=799; pix_valid=0 until relock two vsync rises later.
REQ-027 hsync width 95 during CHECK -> sync_err at the hsync fall; state SEARCH; locked stays 0.
REQ-028 hsync held low 1100 clocks while locked -> timeout violation at h=1023; sync_err=1; locked drops; line_len=1023 at the next hsync rise.
REQ-029 sys_rst_n pulsed low mid-active-line while locked -> all outputs return to reset values asynchronously; err_cnt=0; pix_valid resumes only after two further vsync rises.
